// File: rtl/triple_diffusion_stage_if.sv
// Bundle of the signals between the diffusion stage and the blocks around it:
// the start/busy/done controls, the fetch pulse and returned plain triple from
// the memory reader, the keystream triple with its valid/ready pair, and the
// cipher triple with its valid/ready pair.
//   master : the diffusion stage itself
//   slave  : the environment (reader, keystream generator, downstream sink)
interface triple_diffusion_stage_if;
  logic        start;
  logic        enable_read;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] val3;
  logic [31:0] key1;
  logic [31:0] key2;
  logic [31:0] key3;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] out1;
  logic [31:0] out2;
  logic [31:0] out3;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  modport master (
    input  start, val1, val2, val3, key1, key2, key3, key_valid, out_ready,
    output enable_read, key_ready, out1, out2, out3, out_valid, busy, done
  );

  modport slave (
    output start, val1, val2, val3, key1, key2, key3, key_valid, out_ready,
    input  enable_read, key_ready, out1, out2, out3, out_valid, busy, done
  );
endinterface

// File: rtl/triple_diffusion_stage.sv
// Chained-XOR diffusion stage. Fetches a plain triple from the memory reader,
// mixes it with a keystream triple so each cipher word depends on every
// earlier word of the image, and offers the result on a valid/ready output.
// Reports done after NUM_TRIPLES triples.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - master side of triple_diffusion_stage_if (start/busy/done,
//          reader fetch + val1..3, keystream key1..3 handshake,
//          cipher out1..3 handshake)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start after reset
// FETCH | enable_read high for this one cycle
// CAPT  | reader data valid; latch val1..3
// MIX   | key_ready high; wait for key_valid, compute cipher triple
// HOLD  | out_valid high; wait for out_ready, advance triple count
// DONE  | image complete; done high, last triple held, start restarts
module triple_diffusion_stage #(
  parameter int          NUM_TRIPLES = 900,
  parameter logic [31:0] IV          = 32'h0000_0000,
  // 2**CNT_W must cover NUM_TRIPLES
  parameter int          CNT_W       = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  triple_diffusion_stage_if.master   bus
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPT, MIX, HOLD, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TRIPLES - 1);

  state_t           state;
  logic [31:0]      p1, p2, p3;
  logic [31:0]      chain;
  logic [CNT_W-1:0] count;
  logic [31:0]      out1_q, out2_q, out3_q;
  logic             enable_read_q, out_valid_q, busy_q, done_q;

  // Each word folds in the previous cipher word, so the chain runs
  // chain -> out1 -> out2 -> out3 -> next triple's chain.
  logic [31:0] c1, c2, c3;
  assign c1 = p1 ^ bus.key1 ^ chain;
  assign c2 = p2 ^ bus.key2 ^ c1;
  assign c3 = p3 ^ bus.key3 ^ c2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      p1            <= '0;
      p2            <= '0;
      p3            <= '0;
      chain         <= IV;
      count         <= '0;
      out1_q        <= '0;
      out2_q        <= '0;
      out3_q        <= '0;
      enable_read_q <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      enable_read_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            chain         <= IV;
            count         <= '0;
            enable_read_q <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            state         <= FETCH;
          end
        end
        FETCH: state <= CAPT;
        CAPT: begin
          p1    <= bus.val1;
          p2    <= bus.val2;
          p3    <= bus.val3;
          state <= MIX;
        end
        MIX: begin
          if (bus.key_valid) begin
            out1_q      <= c1;
            out2_q      <= c2;
            out3_q      <= c3;
            chain       <= c3;
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (count == LAST) begin
              // count holds at LAST rather than wrapping
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              count         <= count + CNT_W'(1);
              enable_read_q <= 1'b1;
              state         <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.enable_read = enable_read_q;
  assign bus.key_ready   = (state == MIX);
  assign bus.out1        = out1_q;
  assign bus.out2        = out2_q;
  assign bus.out3        = out3_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_triple_diffusion_stage.sv
module tb_triple_diffusion_stage;

  logic clk;
  logic rst;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   er_cnt   = 0;

  triple_diffusion_stage_if bus();

  triple_diffusion_stage #(
    .NUM_TRIPLES(3),
    .IV(32'h0000_0000),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock, sample 1 time unit after the edge, count fetch pulses
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.enable_read === 1'b1) er_cnt++;
  endtask

  task automatic set_data(input logic [31:0] v1, v2, v3, k1, k2, k3);
    bus.val1 = v1; bus.val2 = v2; bus.val3 = v3;
    bus.key1 = k1; bus.key2 = k2; bus.key3 = k3;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.key_valid = 1'b0; bus.out_ready = 1'b0;
    set_data(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_cnt++;
    if ({bus.enable_read, bus.key_ready, bus.out_valid, bus.busy, bus.done} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.enable_read, bus.key_ready, bus.out_valid, bus.busy, bus.done});
    else pass_cnt++;
    chk_cnt++;
    if ({bus.out1, bus.out2, bus.out3} !== 96'h0)
      $display("FAIL reset_out: got %h expected 0", {bus.out1, bus.out2, bus.out3});
    else pass_cnt++;
    rst = 1'b1;
    tick(); tick();
    chk_cnt++;
    if ({bus.busy, bus.key_ready, bus.enable_read} !== 3'b0)
      $display("FAIL idle_quiet: got %b expected 000",
               {bus.busy, bus.key_ready, bus.enable_read});
    else pass_cnt++;
  endtask

  task automatic test_first_triple();
    er_cnt = 0;
    set_data(1, 2, 3, 32'h10, 32'h20, 32'h30);
    bus.key_valid = 1'b1; bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_cnt++;
    if ({bus.busy, bus.enable_read} !== 2'b11)
      $display("FAIL start_fetch: got %b expected 11", {bus.busy, bus.enable_read});
    else pass_cnt++;
    tick(); tick(); tick();
    chk_cnt++;
    if (bus.out_valid !== 1'b1)
      $display("FAIL first_latency: got out_valid=%b expected 1", bus.out_valid);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.out1, bus.out2, bus.out3} !== {32'h11, 32'h33, 32'h0})
      $display("FAIL first_triple: got %h expected %h",
               {bus.out1, bus.out2, bus.out3}, {32'h11, 32'h33, 32'h0});
    else pass_cnt++;
  endtask

  task automatic test_chaining();
    set_data(4, 5, 6, 0, 0, 0);
    tick(); tick(); tick(); tick();
    chk_cnt++;
    if ({bus.out_valid, bus.out1, bus.out2, bus.out3} !== {1'b1, 32'h4, 32'h1, 32'h7})
      $display("FAIL chained_triple: got %b %h expected 1 %h", bus.out_valid,
               {bus.out1, bus.out2, bus.out3}, {32'h4, 32'h1, 32'h7});
    else pass_cnt++;
    chk_cnt++;
    if (er_cnt !== 2) $display("FAIL fetch_count_2: got %0d expected 2", er_cnt);
    else pass_cnt++;
  endtask

  task automatic test_key_stall();
    int  base;
    bit  bad;
    bus.key_valid = 1'b0;
    set_data(7, 8, 9, 1, 2, 3);
    tick(); tick(); tick();
    chk_cnt++;
    if (bus.key_ready !== 1'b1) $display("FAIL mix_key_ready: got %b expected 1", bus.key_ready);
    else pass_cnt++;
    base = er_cnt;
    bad  = 1'b0;
    repeat (10) begin
      tick();
      if (bus.key_ready !== 1'b1 || bus.out_valid !== 1'b0) bad = 1'b1;
    end
    chk_cnt++;
    if (bad) $display("FAIL key_stall: got stall_broken=1 expected 0");
    else pass_cnt++;
    chk_cnt++;
    if (er_cnt !== base) $display("FAIL stall_no_fetch: got %0d expected %0d", er_cnt, base);
    else pass_cnt++;
  endtask

  task automatic test_hold_stall();
    bit bad;
    bus.out_ready = 1'b0;
    bus.key_valid = 1'b1;
    tick();
    // chain after second triple is 7: (7^1^7, 8^2^1, 9^3^0xB)
    chk_cnt++;
    if ({bus.out_valid, bus.out1, bus.out2, bus.out3} !== {1'b1, 32'h1, 32'hB, 32'h1})
      $display("FAIL third_triple: got %b %h expected 1 %h", bus.out_valid,
               {bus.out1, bus.out2, bus.out3}, {32'h1, 32'hB, 32'h1});
    else pass_cnt++;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if ({bus.out_valid, bus.out1, bus.out2, bus.out3} !== {1'b1, 32'h1, 32'hB, 32'h1}
          || bus.done !== 1'b0) bad = 1'b1;
    end
    chk_cnt++;
    if (bad) $display("FAIL hold_stable: got changed=1 expected 0");
    else pass_cnt++;
    bus.out_ready = 1'b1;
    tick();
    chk_cnt++;
    if ({bus.out_valid, bus.done, bus.busy} !== 3'b010)
      $display("FAIL done_after_third: got %b expected 010",
               {bus.out_valid, bus.done, bus.busy});
    else pass_cnt++;
    chk_cnt++;
    if (er_cnt !== 3) $display("FAIL image_fetches: got %0d expected 3", er_cnt);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.out1, bus.out2, bus.out3} !== {32'h1, 32'hB, 32'h1})
      $display("FAIL done_retains: got %h expected %h",
               {bus.out1, bus.out2, bus.out3}, {32'h1, 32'hB, 32'h1});
    else pass_cnt++;
  endtask

  task automatic test_restart();
    bit ok;
    er_cnt = 0;
    set_data(1, 2, 3, 32'h10, 32'h20, 32'h30);
    bus.key_valid = 1'b1; bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_cnt++;
    if ({bus.done, bus.busy} !== 2'b01)
      $display("FAIL restart_flags: got %b expected 01", {bus.done, bus.busy});
    else pass_cnt++;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk_cnt++;
    if ({bus.out_valid, bus.out1, bus.out2, bus.out3} !== {1'b1, 32'h11, 32'h33, 32'h0})
      $display("FAIL restart_iv: got %b %h expected 1 %h", bus.out_valid,
               {bus.out1, bus.out2, bus.out3}, {32'h11, 32'h33, 32'h0});
    else pass_cnt++;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (!ok) $display("FAIL restart_done: got done=0 expected 1 within 40 cycles");
    else pass_cnt++;
    chk_cnt++;
    if (er_cnt !== 3) $display("FAIL restart_fetches: got %0d expected 3", er_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_hold();
    er_cnt = 0;
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk_cnt++;
    if (bus.out_valid !== 1'b1) $display("FAIL pre_reset_hold: got %b expected 1", bus.out_valid);
    else pass_cnt++;
    #3;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.enable_read, bus.key_ready, bus.out_valid, bus.busy, bus.done,
         bus.out1, bus.out2, bus.out3} !== 101'h0)
      $display("FAIL async_reset: got %b %h expected all zero",
               {bus.enable_read, bus.key_ready, bus.out_valid, bus.busy, bus.done},
               {bus.out1, bus.out2, bus.out3});
    else pass_cnt++;
    #1;
    rst = 1'b1;
    tick();
    er_cnt = 0;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk_cnt++;
    if ({bus.out_valid, bus.out1, bus.out2, bus.out3} !== {1'b1, 32'h11, 32'h33, 32'h0}
        || er_cnt !== 1)
      $display("FAIL post_reset_image: got %b %h fetches=%0d expected 1 %h fetches=1",
               bus.out_valid, {bus.out1, bus.out2, bus.out3}, er_cnt,
               {32'h11, 32'h33, 32'h0});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_triple();
    test_chaining();
    test_key_stall();
    test_hold_stall();
    test_restart();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
